// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow clock (sig_in) in clk_in cycles.
// sig_in is synchronized, rising edges restart the counters and publish the last count.
module clock_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic [WIDTH-1:0] n_out,
  output logic             balanced,
  output logic             valid,
  output logic             timeout
);

  // state   | meaning
  // IDLE    | unarmed, waiting for the first rising edge of sig_s
  // MEASURE | counting clk_in cycles since the last rising edge
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic             sync1;
  logic             sig_s;
  logic             sig_d;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hcnt;
  logic             cnt_max;
  logic             do_restart;
  logic             do_load;
  logic             do_count;
  logic             do_timeout;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sig_s <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sig_s <= sync1;
      sig_d <= sig_s;
    end
  end

  assign rise    = sig_s & ~sig_d;
  assign cnt_max = (cnt == ALL_ONES);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise) state_next = MEASURE;
        MEASURE: if (!rise && cnt_max) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A rise coincident with a full counter still wins over the timeout.
  always_comb begin
    do_restart = 1'b0;
    do_load    = 1'b0;
    do_count   = 1'b0;
    do_timeout = 1'b0;
    if (en) begin
      case (state)
        IDLE: do_restart = rise;
        MEASURE: begin
          if (rise) begin
            do_restart = 1'b1;
            do_load    = 1'b1;
          end else if (cnt_max) begin
            do_timeout = 1'b1;
          end else begin
            do_count   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (do_restart) begin
      cnt  <= ONE;
      hcnt <= ONE;
    end else if (do_count) begin
      cnt <= cnt_max ? cnt : cnt + ONE;
      if (sig_s && (hcnt != ALL_ONES)) hcnt <= hcnt + ONE;
    end else begin
      cnt  <= '0;
      hcnt <= '0;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      period_out <= '0;
      high_out   <= '0;
      n_out      <= '0;
      balanced   <= 1'b0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      valid <= do_load;
      if (do_load) begin
        period_out <= cnt;
        high_out   <= hcnt;
        n_out      <= cnt >> 1;
        balanced   <= ({hcnt, 1'b0} == {1'b0, cnt});
        timeout    <= 1'b0;
      end else if (do_timeout) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: a 16-bit and a 4-bit instance share one stimulus
// and are compared every cycle against a timestamp-based reference model.
module tb_clock_period_meter;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        en;
  logic        sig_in;
  logic [15:0] p16, h16, n16;
  logic        b16, v16, t16;
  logic [3:0]  p4, h4, n4;
  logic        b4, v4, t4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  clock_period_meter #(.WIDTH(16)) dut16 (
    .clk_in(clk_in), .reset(reset), .en(en), .sig_in(sig_in),
    .period_out(p16), .high_out(h16), .n_out(n16),
    .balanced(b16), .valid(v16), .timeout(t16)
  );

  clock_period_meter #(.WIDTH(4)) dut4 (
    .clk_in(clk_in), .reset(reset), .en(en), .sig_in(sig_in),
    .period_out(p4), .high_out(h4), .n_out(n4),
    .balanced(b4), .valid(v4), .timeout(t4)
  );

  // Reference model: rises are timestamped; period is the distance between
  // timestamps, high time is the count of high synchronized cycles in between.
  int  m_armed [2];
  int  m_r     [2];
  int  m_per   [2];
  int  m_high  [2];
  int  m_bal   [2];
  int  m_val   [2];
  int  m_tmo   [2];
  int  maxv    [2] = '{65535, 15};
  bit  s1, s2, s3;
  int  cyc = 0;
  bit  hist [4096];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_armed[i] = 0; m_r[i] = 0; m_per[i] = 0; m_high[i] = 0;
      m_bal[i] = 0; m_val[i] = 0; m_tmo[i] = 0;
    end
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
  endtask

  task automatic model_step();
    bit cur, prv, rise_m;
    cur    = s2;
    prv    = s3;
    rise_m = cur && !prv;
    hist[cyc % 4096] = cur;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0;
      if (!en) begin
        m_armed[i] = 0;
      end else if (rise_m) begin
        if (m_armed[i] != 0) begin
          m_per[i]  = cyc - m_r[i];
          m_high[i] = 0;
          for (int k = m_r[i]; k < cyc; k++) m_high[i] += int'(hist[k % 4096]);
          m_bal[i]  = (2 * m_high[i] == m_per[i]) ? 1 : 0;
          m_val[i]  = 1;
          m_tmo[i]  = 0;
        end
        m_armed[i] = 1;
        m_r[i]     = cyc;
      end else if (m_armed[i] != 0 && (cyc - m_r[i]) == maxv[i]) begin
        m_armed[i] = 0;
        m_tmo[i]   = 1;
      end
    end
    s3 = s2;
    s2 = s1;
    s1 = sig_in;
    cyc++;
  endtask

  task automatic check_all();
    check("period16",   32'(p16), m_per[0]);
    check("high16",     32'(h16), m_high[0]);
    check("n16",        32'(n16), m_per[0] >> 1);
    check("balanced16", 32'(b16), m_bal[0]);
    check("valid16",    32'(v16), m_val[0]);
    check("timeout16",  32'(t16), m_tmo[0]);
    check("period4",    32'(p4),  m_per[1]);
    check("high4",      32'(h4),  m_high[1]);
    check("n4",         32'(n4),  m_per[1] >> 1);
    check("balanced4",  32'(b4),  m_bal[1]);
    check("valid4",     32'(v4),  m_val[1]);
    check("timeout4",   32'(t4),  m_tmo[1]);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (!reset) model_reset();
    else        model_step();
    check_all();
  endtask

  task automatic step(input bit s);
    sig_in = s;
    tick();
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  task automatic pulse_reset();
    #3;
    reset = 1'b0;
    #1;
    check("rst_now_period16", 32'(p16), 0);
    check("rst_now_high16",   32'(h16), 0);
    check("rst_now_valid16",  32'(v16), 0);
    check("rst_now_period4",  32'(p4),  0);
    check("rst_now_timeout4", 32'(t4),  0);
    model_reset();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset  = 1'b0;
    en     = 1'b0;
    sig_in = 1'b0;
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    en    = 1'b1;

    // divide-by-2
    wave(1, 1, 6);
    check("div2_period", 32'(p16), 2);
    check("div2_high",   32'(h16), 1);
    check("div2_n",      32'(n16), 1);
    check("div2_bal",    32'(b16), 1);

    // 4 high / 4 low
    wave(4, 4, 4);
    check("n4_period", 32'(p16), 8);
    check("n4_high",   32'(h16), 4);
    check("n4_n",      32'(n16), 4);
    check("n4_bal",    32'(b16), 1);

    // 3 high / 2 low
    wave(3, 2, 4);
    check("3h2l_period", 32'(p16), 5);
    check("3h2l_high",   32'(h16), 3);
    check("3h2l_n",      32'(n16), 2);
    check("3h2l_bal",    32'(b16), 0);

    // one rise then static: 4-bit instance times out, then recovers
    repeat (25) step(1'b1);
    check("tmo_set4", 32'(t4), 1);
    repeat (4) step(1'b0);
    wave(4, 4, 3);
    check("tmo_recover_period4", 32'(p4), 8);
    check("tmo_recover_clear4",  32'(t4), 0);

    // period exactly at the 4-bit counter limit is still a measurement
    wave(7, 8, 3);
    check("limit_period4", 32'(p4), 15);
    check("limit_tmo4",    32'(t4), 0);
    wave(8, 8, 2);
    check("over_tmo4",    32'(t4), 1);
    check("over_period4", 32'(p4), 15);

    // reset pulse in the low phase of an 8-cycle stream
    wave(4, 4, 2);
    repeat (4) step(1'b1);
    repeat (2) step(1'b0);
    pulse_reset();
    repeat (2) step(1'b0);
    wave(4, 4, 3);
    check("rst_period16", 32'(p16), 8);
    check("rst_period4",  32'(p4),  8);

    // enable dropped for 3 cycles
    wave(4, 4, 2);
    en = 1'b0;
    repeat (3) step(1'b1);
    en = 1'b1;
    step(1'b1);
    repeat (4) step(1'b0);
    wave(4, 4, 3);
    check("en_period16", 32'(p16), 8);

    // randomized periods, duty cycles and enable drops
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(9) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(3, 1)) step(sig_in);
        en = 1'b1;
      end
      wave($urandom_range(9, 1), $urandom_range(9, 1), 1);
    end
    repeat (20) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
